// File: rtl/freq_bcd_capture.sv
// Captures the gated pulse count on each gate fall and converts it to packed BCD
// with a shift-add-3 loop (one bit per clock), publishing a stable result.
module freq_bcd_capture #(
   parameter int unsigned CNT_W       = 24,
   parameter int unsigned DIGITS      = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic                  gate,
   input  logic [CNT_W-1:0]      count_in,
   input  logic                  hold,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  bcd_valid,
   output logic                  busy,
   output logic                  overrun
);

   localparam int unsigned BCD_W   = 4 * DIGITS;
   localparam int unsigned ITER_W  = $clog2(CNT_W + 1);
   localparam int unsigned SHIFT_W = BCD_W + CNT_W;

   typedef enum logic [0:0] {IDLE, CONV} state_t;

   state_t               state, state_next;
   logic [SYNC_STAGES-1:0] gate_sync;
   logic [CNT_W-1:0]     c_d [SYNC_STAGES];
   logic                 gate_s, gate_q, fall_c;
   logic [CNT_W-1:0]     hold_reg;
   logic [SHIFT_W-1:0]   shift, shift_next;
   logic [ITER_W-1:0]    iter, iter_next;
   logic [BCD_W-1:0]     bcd_next;
   logic                 valid_next, busy_next, overrun_next;

   // Add 3 to every nibble >= 5; nibbles are independent, no carry between them.
   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      logic [3:0]       nib;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         nib = v[4*i +: 4];
         if (nib >= 4'd5) r[4*i +: 4] = nib + 4'd3;
      end
      return r;
   endfunction

   assign gate_s = gate_sync[SYNC_STAGES-1];
   assign fall_c = gate_q & ~gate_s;

   // Gate synchroniser with a matching count delay line; capture only coherent count samples.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         gate_sync <= '0;
         gate_q    <= 1'b0;
         hold_reg  <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) c_d[i] <= '0;
      end else begin
         gate_sync <= {gate_sync[SYNC_STAGES-2:0], gate};
         gate_q    <= gate_s;
         c_d[0]    <= count_in;
         for (int i = 1; i < SYNC_STAGES; i++) c_d[i] <= c_d[i-1];
         if (gate_s && (c_d[SYNC_STAGES-1] == c_d[SYNC_STAGES-2]))
            hold_reg <= c_d[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state     <= IDLE;
         shift     <= '0;
         iter      <= '0;
         bcd       <= '0;
         bcd_valid <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_next;
         shift     <= shift_next;
         iter      <= iter_next;
         bcd       <= bcd_next;
         bcd_valid <= valid_next;
         busy      <= busy_next;
         overrun   <= overrun_next;
      end
   end

   always_comb begin
      state_next   = state;
      shift_next   = shift;
      iter_next    = iter;
      bcd_next     = bcd;
      valid_next   = 1'b0;
      overrun_next = 1'b0;
      case (state)
         IDLE: begin
            if (fall_c) begin
               shift_next = {BCD_W'(0), hold_reg};
               iter_next  = '0;
               state_next = CONV;
            end
         end
         CONV: begin
            // A fall during conversion is dropped and flagged; the running conversion continues.
            overrun_next = fall_c;
            shift_next   = {add3(shift[SHIFT_W-1 -: BCD_W]), shift[CNT_W-1:0]} << 1;
            iter_next    = iter + ITER_W'(1);
            if (iter == ITER_W'(CNT_W - 1)) begin
               state_next = IDLE;
               if (!hold) begin
                  bcd_next   = shift_next[SHIFT_W-1 -: BCD_W];
                  valid_next = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next == CONV);
   end

endmodule

// File: tb/tb_freq_bcd_capture.sv
// Scoreboard bench for freq_bcd_capture: stimulus queues expected results with
// their due cycle, a monitor pops them whenever bcd_valid pulses.
module tb_freq_bcd_capture;

   localparam int unsigned CNT_W = 24;
   localparam int unsigned DIGITS = 8;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int LAT = SYNC_STAGES + 1 + CNT_W;   // gate drive cycle -> bcd_valid cycle

   typedef struct {
      logic [31:0] val;
      int          due;
   } exp_t;

   logic              sys_clk = 1'b0;
   logic              rst = 1'b1;
   logic              gate = 1'b0;
   logic [CNT_W-1:0]  count_in = '0;
   logic              hold = 1'b0;
   logic [4*DIGITS-1:0] bcd;
   logic              bcd_valid, busy, overrun;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sb[$];

   freq_bcd_capture #(.CNT_W(CNT_W), .DIGITS(DIGITS), .SYNC_STAGES(SYNC_STAGES)) dut (
      .sys_clk(sys_clk), .rst(rst), .gate(gate), .count_in(count_in), .hold(hold),
      .bcd(bcd), .bcd_valid(bcd_valid), .busy(busy), .overrun(overrun)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every bcd_valid must match the oldest queued result, at its due cycle.
   always @(negedge sys_clk) begin
      if (bcd_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 64'(bcd), 64'hDEAD_BEEF_DEAD_BEEF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("bcd_value", 64'(bcd), 64'(e.val));
            chk("valid_cycle", 64'(cyc), 64'(e.due));
         end
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic wait_to(input int target);
      while (cyc < target) tick();
      @(negedge sys_clk);
   endtask

   task automatic start_gate(input logic [CNT_W-1:0] val, input int n);
      gate = 1'b1;
      count_in = val;
      repeat (n) tick();
   endtask

   task automatic drop_gate(input logic [31:0] exp, input bit push, output int k);
      gate = 1'b0;
      count_in = '0;
      k = cyc;
      if (push) sb.push_back('{val: exp, due: k + LAT});
   endtask

   initial begin
      int k;
      repeat (3) tick();
      @(negedge sys_clk);
      chk("rst_bcd", 64'(bcd), 64'h0);
      chk("rst_valid", 64'(bcd_valid), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_overrun", 64'(overrun), 64'h0);
      rst = 1'b0;
      tick();

      // 1: steady 1000, plus busy window edges
      start_gate(24'd1000, 6);
      drop_gate(32'h0000_1000, 1'b1, k);
      wait_to(k + 2);  chk("busy_before", 64'(busy), 64'h0);
      wait_to(k + 3);  chk("busy_first", 64'(busy), 64'h1);
      wait_to(k + 26); chk("busy_last", 64'(busy), 64'h1);
      wait_to(k + 27); chk("busy_after", 64'(busy), 64'h0);
      wait_to(k + 32);

      // 2: full-scale and zero
      start_gate(24'hFFFFFF, 6);
      drop_gate(32'h1677_7215, 1'b1, k);
      wait_to(k + 32);
      start_gate(24'd0, 6);
      drop_gate(32'h0000_0000, 1'b1, k);
      wait_to(k + 32);

      // 3: count racing every cycle, stable at the end of the window
      gate = 1'b1;
      for (int i = 0; i < 10; i++) begin
         count_in = CNT_W'(i * 7919 + 13);
         tick();
      end
      start_gate(24'd12345, 4);
      drop_gate(32'h0001_2345, 1'b1, k);
      wait_to(k + 32);
      chk("bcd_hold_3", 64'(bcd), 64'h0001_2345);

      // 4: second fall during conversion -> overrun, first result only
      start_gate(24'd4321, 6);
      drop_gate(32'h0000_4321, 1'b1, k);
      wait_to(k + 5);
      gate = 1'b1;
      count_in = 24'd555;
      wait_to(k + 10);
      gate = 1'b0;
      count_in = '0;
      wait_to(k + 12); chk("ovr_before", 64'(overrun), 64'h0);
      wait_to(k + 13); chk("ovr_pulse", 64'(overrun), 64'h1);
                       chk("ovr_busy", 64'(busy), 64'h1);
      wait_to(k + 14); chk("ovr_after", 64'(overrun), 64'h0);
      wait_to(k + 45);
      chk("bcd_after_ovr", 64'(bcd), 64'h0000_4321);

      // 5: reset at iteration 12 aborts conversion
      start_gate(24'd999, 6);
      drop_gate(32'h0, 1'b0, k);
      wait_to(k + 15);
      chk("busy_pre_rst", 64'(busy), 64'h1);
      rst = 1'b1;
      wait_to(k + 16);
      chk("rst5_bcd", 64'(bcd), 64'h0);
      chk("rst5_busy", 64'(busy), 64'h0);
      chk("rst5_valid", 64'(bcd_valid), 64'h0);
      chk("rst5_overrun", 64'(overrun), 64'h0);
      rst = 1'b0;
      wait_to(k + 50);

      // 6: hold freezes prior result
      start_gate(24'd42, 6);
      drop_gate(32'h0000_0042, 1'b1, k);
      wait_to(k + 32);
      hold = 1'b1;
      start_gate(24'd777, 6);
      drop_gate(32'h0, 1'b0, k);
      wait_to(k + 40);
      chk("bcd_held", 64'(bcd), 64'h0000_0042);
      hold = 1'b0;
      wait_to(k + 45);

      chk("sb_empty", 64'(sb.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
